// File: rtl/nf_time_base.sv
// nf_time_base: tick prescaler, uptime counter, loadable UNIX wall clock and coherent snapshot port
module nf_time_base #(
  parameter int unsigned ACLK_FREQ = 200000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned SIM_DIV   = 1,
  parameter int unsigned MS_WIDTH  = 32
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                enable,
  input  logic                load_valid,
  input  logic [31:0]         load_secs,
  input  logic [31:0]         load_nsecs,
  output logic                load_err,
  output logic                tick,
  output logic [MS_WIDTH-1:0] uptime,
  output logic [31:0]         unix_secs,
  output logic [31:0]         unix_nsecs,
  input  logic                snap_req,
  output logic                snap_valid,
  input  logic                snap_ready,
  output logic [MS_WIDTH-1:0] snap_uptime,
  output logic [31:0]         snap_secs,
  output logic [31:0]         snap_nsecs
);
  localparam int unsigned PRESCALE    = ACLK_FREQ / TICK_HZ / SIM_DIV;
  localparam int unsigned PW          = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [31:0] NS_PER_SEC  = 32'd1000000000;
  localparam logic [31:0] NS_PER_TICK = NS_PER_SEC / TICK_HZ;
  logic [PW-1:0]       presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [MS_WIDTH-1:0] uptime_q, uptime_d;
  logic [31:0]         secs_q, secs_d;
  logic [31:0]         nsecs_q, nsecs_d;
  logic                load_err_q, load_err_d;
  logic                snap_valid_q, snap_valid_d;
  logic [MS_WIDTH-1:0] snap_uptime_q, snap_uptime_d;
  logic [31:0]         snap_secs_q, snap_secs_d;
  logic [31:0]         snap_nsecs_q, snap_nsecs_d;
  logic                tick_edge;
  logic                load_ok;
  logic                sec_roll;
  logic [31:0]         nsecs_step;
  logic                snap_take;
  // Prescaler holds while disabled; its terminal count is the tick edge that also bumps uptime
  always_comb begin
    tick_edge = enable && (presc_q == PRE_LAST);
    presc_d   = !enable ? presc_q : tick_edge ? '0 : presc_q + PW'(1);
    tick_d    = tick_edge;
    uptime_d  = tick_edge ? uptime_q + MS_WIDTH'(1) : uptime_q;
  end
  // Wall clock: a valid load overrides the tick step; nsecs stays below one second so the sum cannot overflow
  always_comb begin
    load_ok    = load_valid && (load_nsecs < NS_PER_SEC);
    load_err_d = load_valid && !load_ok;
    nsecs_step = nsecs_q + NS_PER_TICK;
    sec_roll   = nsecs_step >= NS_PER_SEC;
    secs_d     = load_ok ? load_secs : (tick_edge && sec_roll) ? secs_q + 32'd1 : secs_q;
    nsecs_d    = load_ok ? load_nsecs : !tick_edge ? nsecs_q : sec_roll ? '0 : nsecs_step;
  end
  // Snapshot: capture pre-edge counters only when the holding register is empty; requests while full are dropped
  always_comb begin
    snap_take     = snap_req && !snap_valid_q;
    snap_valid_d  = snap_valid_q ? !snap_ready : snap_req;
    snap_uptime_d = snap_take ? uptime_q : snap_uptime_q;
    snap_secs_d   = snap_take ? secs_q : snap_secs_q;
    snap_nsecs_d  = snap_take ? nsecs_q : snap_nsecs_q;
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      uptime_q      <= '0;
      secs_q        <= '0;
      nsecs_q       <= '0;
      load_err_q    <= 1'b0;
      snap_valid_q  <= 1'b0;
      snap_uptime_q <= '0;
      snap_secs_q   <= '0;
      snap_nsecs_q  <= '0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      uptime_q      <= uptime_d;
      secs_q        <= secs_d;
      nsecs_q       <= nsecs_d;
      load_err_q    <= load_err_d;
      snap_valid_q  <= snap_valid_d;
      snap_uptime_q <= snap_uptime_d;
      snap_secs_q   <= snap_secs_d;
      snap_nsecs_q  <= snap_nsecs_d;
    end
  end
  assign tick        = tick_q;
  assign load_err    = load_err_q;
  assign uptime      = uptime_q;
  assign unix_secs   = secs_q;
  assign unix_nsecs  = nsecs_q;
  assign snap_valid  = snap_valid_q;
  assign snap_uptime = snap_uptime_q;
  assign snap_secs   = snap_secs_q;
  assign snap_nsecs  = snap_nsecs_q;
endmodule
